// File: rtl/line_fetch_sequencer.sv
// Walks the character ROM for one mapped line and streams each pair as a beat.
// A two-entry buffer plus one in-flight read absorbs ROM latency and stalls.
module line_fetch_sequencer #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_line,
   output logic [7:0]  map_line,
   input  logic [15:0] map_ptr,
   output logic [7:0]  mem_addr,
   input  logic [15:0] mem_dout,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_lhs,
   output logic [7:0]  out_rhs,
   output logic [7:0]  out_index,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] FETCH  = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [7:0]  line_q;
   logic [7:0]  len_q;
   logic [7:0]  remaining;
   logic [7:0]  issue_addr;
   logic [7:0]  beat_cnt;
   logic        inflight;
   logic        done_q;
   logic [15:0] fifo_data [2];
   logic [7:0]  fifo_idx [2];
   logic        fifo_last [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  fifo_count;
   logic [1:0]  occ;
   logic        pop;
   logic        issue;
   logic        drain_done;

   assign pop = out_valid & out_ready;
   assign occ = fifo_count + {1'b0, inflight};

   // The in-flight read lands this cycle, so credit is counted after the pop.
   assign issue = (state == FETCH) && (remaining != 8'd0)
                  && (occ < DEPTH + {1'b0, pop});

   assign drain_done = !inflight && (fifo_count == {1'b0, pop});

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (req_valid) state_nx = LOOKUP;
         LOOKUP:
            state_nx = (map_ptr[15:8] == 8'd0) ? IDLE : FETCH;
         FETCH:
            if (issue && remaining == 8'd1) state_nx = DRAIN;
         DRAIN:
            if (drain_done) state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         line_q     <= 8'd0;
         len_q      <= 8'd0;
         remaining  <= 8'd0;
         issue_addr <= 8'd0;
         beat_cnt   <= 8'd0;
         inflight   <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= 16'd0;
            fifo_idx[i]  <= 8'd0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         if (state == IDLE && req_valid) line_q <= req_line;
         if (state == LOOKUP) begin
            len_q      <= map_ptr[15:8];
            remaining  <= map_ptr[15:8];
            issue_addr <= map_ptr[7:0];
            beat_cnt   <= 8'd0;
            if (map_ptr[15:8] == 8'd0) done_q <= 1'b1;
         end
         if (state == DRAIN && drain_done) done_q <= 1'b1;
         if (issue) begin
            issue_addr <= issue_addr + 8'd1;
            remaining  <= remaining - 8'd1;
         end
         inflight <= issue;
         if (inflight) begin
            fifo_data[wr_ptr] <= mem_dout;
            fifo_idx[wr_ptr]  <= beat_cnt;
            fifo_last[wr_ptr] <= (beat_cnt == len_q - 8'd1);
            wr_ptr            <= ~wr_ptr;
            beat_cnt          <= beat_cnt + 8'd1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign map_line  = line_q;
   assign mem_addr  = issue ? issue_addr : 8'hFF;
   assign out_valid = (fifo_count != 2'd0);
   assign out_lhs   = fifo_data[rd_ptr][15:8];
   assign out_rhs   = fifo_data[rd_ptr][7:0];
   assign out_index = fifo_idx[rd_ptr];
   assign out_last  = fifo_last[rd_ptr];

endmodule

// File: tb/tb_line_fetch_sequencer.sv
// Directed bench for line_fetch_sequencer with a {addr,~addr} ROM
// and a small table-driven line mapper.
module tb_line_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_line = 8'd0;
   logic [7:0]  map_line;
   logic [15:0] map_ptr;
   logic [7:0]  mem_addr;
   logic [15:0] mem_dout = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_lhs;
   logic [7:0]  out_rhs;
   logic [7:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [15:0] map_tab [8];

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] b_lhs [32];
   logic [7:0] b_rhs [32];
   logic [7:0] b_idx [32];
   logic       b_last [32];
   int         b_cyc [32];
   int         nb;
   logic [7:0] addr_at [64];
   logic [7:0] iss [32];
   int         n_iss;
   int         first_valid;
   int         done_cyc;
   int         busy_n;
   int         stab_err;
   int         occ_err;

   line_fetch_sequencer #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
      .map_line(map_line), .map_ptr(map_ptr),
      .mem_addr(mem_addr), .mem_dout(mem_dout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lhs(out_lhs), .out_rhs(out_rhs),
      .out_index(out_index), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_dout <= {mem_addr, ~mem_addr};

   assign map_ptr = map_tab[map_line[2:0]];

   task automatic run_line(input logic [7:0] line, input int mode, input int maxc);
      logic       prev_stall;
      logic [7:0] p_lhs, p_rhs, p_idx;
      logic       p_last;
      nb = 0; n_iss = 0; first_valid = -1; done_cyc = -1;
      busy_n = 0; stab_err = 0; occ_err = 0;
      prev_stall = 1'b0;
      p_lhs = 0; p_rhs = 0; p_idx = 0; p_last = 0;
      for (int i = 0; i < 64; i++) addr_at[i] = 8'hFF;
      @(posedge clk); #1;
      req_valid = 1'b1; req_line = line; out_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int cyc = 1; cyc <= maxc; cyc++) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
         @(negedge clk);
         addr_at[cyc] = mem_addr;
         if (mem_addr != 8'hFF && n_iss < 32) begin
            iss[n_iss] = mem_addr;
            n_iss++;
         end
         if (busy) busy_n++;
         if (prev_stall && (!out_valid || out_lhs !== p_lhs || out_rhs !== p_rhs
                            || out_index !== p_idx || out_last !== p_last))
            stab_err++;
         prev_stall = out_valid && !out_ready;
         p_lhs = out_lhs; p_rhs = out_rhs; p_idx = out_index; p_last = out_last;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready && nb < 32) begin
            b_lhs[nb] = out_lhs; b_rhs[nb] = out_rhs;
            b_idx[nb] = out_index; b_last[nb] = out_last;
            b_cyc[nb] = cyc;
            nb++;
         end
         if (n_iss - nb > 2) occ_err++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: req_ready=%b busy=%b done=%b, want 1 0 0",
                  req_ready, busy, done);
      end
      n_chk++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_out: valid=%b last=%b index=%h, want 0 0 00",
                  out_valid, out_last, out_index);
      end
      n_chk++;
      if (out_lhs !== 8'd0 || out_rhs !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_data: lhs=%h rhs=%h, want 00 00", out_lhs, out_rhs);
      end
      n_chk++;
      if (mem_addr !== 8'hFF || map_line !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_addr: mem_addr=%h map_line=%h, want FF 00",
                  mem_addr, map_line);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] e;
      run_line(8'd0, 0, 40);
      n_chk++;
      if (addr_at[1] !== 8'hFF || addr_at[2] !== 8'h00) begin
         n_fail++;
         $display("FAIL basic_addr: c1=%h c2=%h, want FF 00", addr_at[1], addr_at[2]);
      end
      n_chk++;
      if (first_valid != 4) begin
         n_fail++;
         $display("FAIL basic_latency: first valid cycle %0d, want 4", first_valid);
      end
      n_chk++;
      if (nb != 3) begin
         n_fail++;
         $display("FAIL basic_count: %0d beats, want 3", nb);
      end
      for (int i = 0; i < 3; i++) begin
         e = 8'(i);
         n_chk++;
         if (b_lhs[i] !== e || b_rhs[i] !== ~e || b_idx[i] !== e
             || b_last[i] !== (i == 2)) begin
            n_fail++;
            $display("FAIL basic_beat%0d: %h,%h idx %h last %b, want %h,%h idx %h last %b",
                     i, b_lhs[i], b_rhs[i], b_idx[i], b_last[i], e, ~e, e, (i == 2));
         end
      end
      n_chk++;
      if (b_cyc[0] != 4 || b_cyc[2] != 6 || done_cyc != 7) begin
         n_fail++;
         $display("FAIL basic_done: beats c%0d..c%0d done c%0d, want 4..6 done 7",
                  b_cyc[0], b_cyc[2], done_cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      run_line(8'd1, 1, 40);
      n_chk++;
      if (nb != 5 || n_iss != 5) begin
         n_fail++;
         $display("FAIL bp_count: beats %0d issues %0d, want 5 5", nb, n_iss);
      end
      for (int i = 0; i < 5; i++) begin
         e = 8'h03 + 8'(i);
         n_chk++;
         if (iss[i] !== e || b_lhs[i] !== e || b_rhs[i] !== ~e
             || b_idx[i] !== 8'(i)) begin
            n_fail++;
            $display("FAIL bp_beat%0d: addr %h lhs %h rhs %h idx %h, want %h %h %h %h",
                     i, iss[i], b_lhs[i], b_rhs[i], b_idx[i], e, e, ~e, 8'(i));
         end
      end
      n_chk++;
      if (stab_err != 0 || occ_err != 0) begin
         n_fail++;
         $display("FAIL bp_stall: stability errs %0d credit errs %0d, want 0 0",
                  stab_err, occ_err);
      end
      n_chk++;
      if (b_last[4] !== 1'b1 || done_cyc != b_cyc[4] + 1) begin
         n_fail++;
         $display("FAIL bp_done: last %b done c%0d, want 1 c%0d",
                  b_last[4], done_cyc, b_cyc[4] + 1);
      end
   endtask

   task automatic test_zero_len();
      run_line(8'd2, 0, 20);
      n_chk++;
      if (first_valid != -1 || n_iss != 0) begin
         n_fail++;
         $display("FAIL zero_quiet: first valid %0d issues %0d, want -1 0",
                  first_valid, n_iss);
      end
      n_chk++;
      if (done_cyc != 2 || busy_n != 1) begin
         n_fail++;
         $display("FAIL zero_done: done c%0d busy %0d cycles, want c2 1",
                  done_cyc, busy_n);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      run_line(8'd3, 0, 40);
      n_chk++;
      if (addr_at[2] !== 8'hFE || addr_at[3] !== 8'hFF
          || addr_at[4] !== 8'h00 || addr_at[5] !== 8'h01) begin
         n_fail++;
         $display("FAIL wrap_addr: %h %h %h %h, want FE FF 00 01",
                  addr_at[2], addr_at[3], addr_at[4], addr_at[5]);
      end
      n_chk++;
      if (nb != 4) begin
         n_fail++;
         $display("FAIL wrap_count: %0d beats, want 4", nb);
      end
      for (int i = 0; i < 4; i++) begin
         e = 8'hFE + 8'(i);
         n_chk++;
         if (b_lhs[i] !== e || b_rhs[i] !== ~e || b_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL wrap_beat%0d: %h,%h last %b, want %h,%h last %b",
                     i, b_lhs[i], b_rhs[i], b_last[i], e, ~e, (i == 3));
         end
      end
   endtask

   task automatic test_reset_mid();
      int got;
      logic [7:0] e;
      got = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_line = 8'd4; out_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 30 && got < 2; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) got++;
         if (got < 2) begin
            @(posedge clk); #1;
         end
      end
      n_chk++;
      if (got != 2) begin
         n_fail++;
         $display("FAIL rstmid_timeout: %0d beats seen, want 2", got);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || mem_addr !== 8'hFF || busy !== 1'b0
          || req_ready !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_abort: valid %b addr %h busy %b rdy %b done %b, want 0 FF 0 1 0",
                  out_valid, mem_addr, busy, req_ready, done);
      end
      @(negedge clk);
      rst = 1'b0;
      run_line(8'd5, 0, 40);
      n_chk++;
      if (nb != 2 || done_cyc < 0) begin
         n_fail++;
         $display("FAIL rstmid_next: %0d beats done c%0d, want 2 beats and done", nb, done_cyc);
      end
      for (int i = 0; i < 2; i++) begin
         e = 8'h40 + 8'(i);
         n_chk++;
         if (b_lhs[i] !== e || b_rhs[i] !== ~e || b_idx[i] !== 8'(i)
             || b_last[i] !== (i == 1)) begin
            n_fail++;
            $display("FAIL rstmid_beat%0d: %h,%h idx %h last %b, want %h,%h idx %h last %b",
                     i, b_lhs[i], b_rhs[i], b_idx[i], b_last[i], e, ~e, 8'(i), (i == 1));
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc [2];
      int dn [2];
      int na, nd;
      logic [7:0] e;
      na = 0; nd = 0; nb = 0;
      acc[0] = -1; acc[1] = -1; dn[0] = -1; dn[1] = -1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_line = 8'd0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nd < 2; cyc++) begin
         @(negedge clk);
         if (req_valid && req_ready && na < 2) begin
            acc[na] = cyc;
            na++;
         end
         if (done && nd < 2) begin
            dn[nd] = cyc;
            nd++;
         end
         if (out_valid && out_ready && nb < 32) begin
            b_lhs[nb] = out_lhs; b_rhs[nb] = out_rhs;
            b_idx[nb] = out_index; b_last[nb] = out_last;
            nb++;
         end
         @(posedge clk); #1;
         if (na == 1) req_line = 8'd1;
         if (na == 2) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      n_chk++;
      if (acc[0] != 0 || dn[0] != 7 || acc[1] != 7 || dn[1] != 16) begin
         n_fail++;
         $display("FAIL b2b_timing: acc %0d,%0d done %0d,%0d, want 0,7 done 7,16",
                  acc[0], acc[1], dn[0], dn[1]);
      end
      n_chk++;
      if (nb != 8) begin
         n_fail++;
         $display("FAIL b2b_count: %0d beats, want 8", nb);
      end
      for (int i = 0; i < 5; i++) begin
         e = 8'h03 + 8'(i);
         n_chk++;
         if (b_lhs[3 + i] !== e || b_rhs[3 + i] !== ~e || b_idx[3 + i] !== 8'(i)
             || b_last[3 + i] !== (i == 4)) begin
            n_fail++;
            $display("FAIL b2b_beat%0d: %h,%h idx %h last %b, want %h,%h idx %h last %b",
                     i, b_lhs[3 + i], b_rhs[3 + i], b_idx[3 + i], b_last[3 + i],
                     e, ~e, 8'(i), (i == 4));
         end
      end
   endtask

   initial begin
      map_tab[0] = 16'h0300;
      map_tab[1] = 16'h0503;
      map_tab[2] = 16'h0010;
      map_tab[3] = 16'h04FE;
      map_tab[4] = 16'h0520;
      map_tab[5] = 16'h0240;
      map_tab[6] = 16'h0000;
      map_tab[7] = 16'h0000;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
